// File: rtl/cla_digit_serial_adder_if.sv
// Operand/result handshake bundle for cla_digit_serial_adder.
// The ovf signal exists only when CLA_OVF_EN is defined.
interface cla_digit_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef CLA_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef CLA_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef CLA_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/cla_digit_serial_adder.sv
// Digit-serial WIDTH-bit adder: one 4-bit carry-lookahead digit per clock, LSD first.
// Optional macro CLA_OVF_EN adds a signed-overflow output (ovf) to the interface.
module cla_digit_serial_adder #(
  parameter int WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst,
  cla_digit_serial_adder_if.slave bus
);

  localparam int NDIG = WIDTH / 4;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("cla_digit_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end
  if ($bits(bus.a) != WIDTH) begin : g_bad_if_width
    $error("cla_digit_serial_adder: interface WIDTH differs from module WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0] dig_a_s, dig_b_s, p_s, g_s, c_s, s_s;

  // Lookahead carries for the digit currently selected by the counter.
  always_comb begin
    dig_a_s = a_q[{cnt_q, 2'b00} +: 4];
    dig_b_s = b_q[{cnt_q, 2'b00} +: 4];
    p_s     = dig_a_s ^ dig_b_s;
    g_s     = dig_a_s & dig_b_s;
    c_s[0]  = g_s[0] | (p_s[0] & carry_q);
    c_s[1]  = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & carry_q);
    c_s[2]  = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
            | (p_s[2] & p_s[1] & p_s[0] & carry_q);
    c_s[3]  = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
            | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
            | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & carry_q);
    s_s     = p_s ^ {c_s[2:0], carry_q};
  end

  // Next-state and datapath updates for IDLE -> RUN -> DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          sum_d   = {WIDTH{1'b0}};
          cnt_d   = {CW{1'b0}};
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[{cnt_q, 2'b00} +: 4] = s_s;
        carry_d = c_s[3];
        // Explicit compare so non-power-of-two digit counts end on time.
        if (cnt_q == LAST_DIG) begin
          cnt_d   = {CW{1'b0}};
          cout_d  = c_s[3];
          ovf_d   = c_s[2] ^ c_s[3];
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      carry_q <= 1'b0;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef CLA_OVF_EN
  assign bus.ovf       = ovf_q;
`else
  // Without the overflow port the captured value has no consumer.
  logic unused_ovf_s;
  assign unused_ovf_s = ovf_q;
`endif

endmodule

// File: doc/cla_digit_serial_adder.md
Name: cla_digit_serial_adder

Overview:
- Digit-serial wide adder built around the team's 4-bit carry-lookahead slice.
- Accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake.
- Adds one 4-bit digit per clock, least-significant digit first, using lookahead equations, and keeps the inter-digit carry in a register.
- Presents the WIDTH-bit sum and carry-out to the downstream consumer through a valid/ready handshake.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be a multiple of 4 and at least 4; any other value fails elaboration.
- NDIG, WIDTH/4, number of digits (localparam, not overridable).

Ports:
- clk  input  1  single clock, all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream presents a, b, cin
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry into digit 0
- out_valid  output  1  sum and cout are valid
- out_ready  input  1  downstream accepts the result
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH
- cout  output  1  carry out of the MSB
- busy  output  1  high in RUN and DONE

Behaviour:
- Reset (rst high at a clock edge): state=IDLE, digit counter=0, carry register=0, operand registers=0, sum=0, cout=0, out_valid=0, busy=0. in_ready is 1 from the first cycle after reset.
- Reset mid-operation: aborts immediately. The partial result is discarded and nothing is emitted.
- FSM state IDLE:
  - in_ready=1.
  - Acceptance occurs on an edge with in_valid=1: latch a, b and cin into the carry register, clear sum and the counter, go to RUN.
- FSM state RUN:
  - in_ready=0. in_valid is ignored and operands are not sampled.
  - Each cycle, digit k = counter selects bits [4k+3:4k] of the latched operands.
  - Per bit: p = a^b, g = a&b.
  - Carries: c0=g0|p0c; c1=g1|p1g0|p1p0c; c2=g2|p2g1|p2p1g0|p2p1p0c; c3=g3|p3g2|p3p2g1|p3p2p1g0|p3p2p1p0c, where c is the carry register.
  - Digit sum bits: s0=p0^c, s1=p1^c0, s2=p2^c1, s3=p3^c2.
  - On the edge: write the digit sum into sum[4k+3:4k], load the carry register with c3, increment the counter.
  - After the edge that processes digit NDIG-1: cout = c3, go to DONE.
- FSM state DONE:
  - out_valid=1. sum and cout are held stable while out_ready=0, for any number of cycles.
  - On an edge with out_ready=1: go to IDLE, out_valid=0.
  - in_ready rises the cycle after the output handshake. There is no same-cycle accept in DONE.
- Timing:
  - Latency: out_valid asserts exactly NDIG cycles after the acceptance edge (4 cycles at WIDTH=16).
  - Throughput: one operation per NDIG+2 cycles minimum, assuming out_ready is held high.
- Width rules:
  - sum is exact modulo 2^WIDTH; cout is the true carry out.
  - At WIDTH=4, one RUN cycle suffices and the counter wraps to 0.
- Counter: width clog2(NDIG), minimum 1 bit. Compare the counter against NDIG-1, never rely on overflow.
- out_valid and in_ready are never high in the same cycle.

Optional Feature:
- Macro: CLA_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), signed two's-complement overflow.
  - ovf = carry into MSB XOR carry out of MSB, captured on the last RUN edge from digit NDIG-1 (c2^c3).
  - ovf is valid with out_valid, held in DONE, and reset to 0.
- Undefined: no ovf port and no extra logic.

Test Plan:
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0 -> after 4 cycles out_valid=1, sum=0x0000, cout=1; checks ripple across all digits.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; out_valid exactly 4 cycles after acceptance, in_ready=0 throughout RUN.
- Backpressure:
  - Stimulus: a=0xA5A5, b=0x5A5A, cin=1, out_ready held 0 for 3 cycles after out_valid.
  - Required: sum=0x0000, cout=1, stable all 3 cycles; IDLE after the handshake; in_ready=1 on the following cycle.
- Input ignored while busy: in_valid=1 with a=0x1111 during RUN -> not sampled; result matches the first operation only.
- rst=1 during the 2nd RUN cycle -> next cycle state IDLE, out_valid=0, sum=0, cout=0, in_ready=1; no result emitted.
- CLA_OVF_EN defined:
  - a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0.
  - a=0xFFFF, b=0x0001 -> ovf=0, cout=1.
